pwm_reg_scheduler: RTL and testbench
====================================

PWM_REG_SCHEDULER -- requirements
Module: pwm_reg_scheduler

Interface
REQ-001 SHALL have parameter MAX_ADDR, default 4, highest valid register address.
REQ-002 SHALL have parameter DIV, default 4, clk cycles per PWM counter step (legal range 1..65535).
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports spi_req/host_req  input  1  write request; the requester holds it high until ack.
REQ-006 SHALL have ports spi_addr/host_addr  input  7  register address, stable while req is high.
REQ-007 SHALL have ports spi_data/host_data  input  8  write data, stable while req is high.
REQ-008 SHALL have ports spi_ack/host_ack  output  1  one-cycle grant pulse.
REQ-009 SHALL have port wr_err  output  1  one-cycle pulse for a granted write with addr > MAX_ADDR.
REQ-010 SHALL have port pwm_out  output  16  PWM/static outputs.
REQ-011 SHALL have port commit  output  1  one-cycle pulse when shadow registers are copied to active registers.

Function
REQ-012 Register map: 0 en_out[7:0]; 1 en_out[15:8]; 2 en_pwm[7:0]; 3 en_pwm[15:8]; 4 duty.
REQ-013 Each register SHALL have a shadow copy and an active copy; only the active copies drive pwm_out.
REQ-014 Arbiter FSM SHALL have two states: IDLE and ACK.
REQ-015 In IDLE, if any req is high, the arbiter SHALL grant one requester and move to ACK.
REQ-016 In ACK, the arbiter SHALL pulse the granted ack for one cycle, write the shadow register, and return to IDLE; maximum throughput is one write per 2 cycles.
REQ-017 When both requesters are active, priority SHALL be round-robin: rr_ptr selects the winner and toggles after every grant. Reset value is SPI.
REQ-018 When only one requester is active, it SHALL be granted regardless of rr_ptr, and rr_ptr SHALL still toggle.
REQ-019 A write with addr > MAX_ADDR SHALL be acked, SHALL pulse wr_err in the same cycle as ack, and SHALL NOT modify any register.
REQ-020 A valid shadow write SHALL set the dirty flag.
REQ-021 An 8-bit counter cnt SHALL advance once every DIV clk cycles via a prescaler, wrapping 255->0.
REQ-022 On the cnt 255->0 step with dirty=1, the block SHALL:
  - copy all shadow registers to active;
  - clear dirty;
  - pulse commit in that same cycle.
REQ-023 If a shadow write and a commit occur in the same cycle:
  - the commit SHALL copy the pre-write shadow values;
  - the write SHALL land in shadow;
  - dirty SHALL remain 1.
REQ-024 pwm_out[i] SHALL be 0 if en_out[i]=0; 1 if en_out[i]=1 and en_pwm[i]=0; otherwise (cnt < duty).
REQ-025 Duty special cases:
  - duty=0x00: PWM bits constantly 0;
  - duty=0xFF: PWM bits constantly 1 (override of the cnt < duty rule).
REQ-026 pwm_out SHALL be registered, lagging cnt/active state by exactly one cycle.

Reset
REQ-027 When rst_n is low, the block SHALL immediately (asynchronously) clear all of the following:
  - shadow and active registers, cnt, prescaler, dirty;
  - pwm_out, spi_ack, host_ack, wr_err, commit;
  - the arbiter FSM, forced to IDLE, with rr_ptr=SPI.
REQ-028 When reset is asserted mid-ACK, the write SHALL be lost with no ack pulse; requesters re-request after reset.
REQ-029 The first prescaler tick SHALL occur DIV cycles after rst_n deasserts.

Structure
REQ-030 The following SHALL live in a shared package pwm_pkg, also used by the SPI peripheral:
  - register address constants (ADDR_EN_OUT_LO..ADDR_DUTY);
  - MAX_ADDR;
  - the arbiter state enum.
REQ-031 The PWM counter/prescaler plus compare logic SHALL be a sub-module pwm_gen (inputs: active registers; outputs: pwm_out, wrap strobe).

Verification
REQ-032 The bench SHALL cover these directed scenarios:
  - SPI write addr 4 data 0x80, addr 0 data 0xFF, addr 2 data 0x01 -> spi_ack pulses; pwm_out unchanged until commit; after commit, pwm_out[0] high for 128 of 256 steps, pwm_out[7:1]=1.
  - spi_req and host_req asserted together twice -> first grant SPI, second HOST; acks never overlap.
  - host write addr 5 -> host_ack and wr_err pulse together; all registers unchanged; no commit at next wrap.
  - duty 0x00 then 0xFF with en_out=en_pwm=0xFFFF -> pwm_out all-zero, then all-ones, across a full period.
  - write issued on the cnt 255->0 step -> old value committed now, new value committed one period later.
  - rst_n pulsed during ACK -> no ack, pwm_out=0, rr_ptr=SPI afterwards.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM register block and the SPI peripheral:
// register map, highest valid address, arbiter states and write request layout.
package pwm_pkg;

    localparam int ADDR_EN_OUT_LO = 0;
    localparam int ADDR_EN_OUT_HI = 1;
    localparam int ADDR_EN_PWM_LO = 2;
    localparam int ADDR_EN_PWM_HI = 3;
    localparam int ADDR_DUTY      = 4;
    localparam int MAX_ADDR       = ADDR_DUTY;
    localparam int NUM_REGS       = ADDR_DUTY + 1;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [6:0] addr;
        logic [7:0] data;
    } wr_req_t;

endpackage

// File: rtl/pwm_gen.sv
// Prescaled 8-bit PWM counter plus per-bit compare against the active registers.
// wrap strobes combinationally on the clock that takes cnt from 255 to 0.
module pwm_gen #(
    parameter int DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] en_out,
    input  logic [15:0] en_pwm,
    input  logic [7:0]  duty,
    output logic [15:0] pwm_out,
    output logic        wrap
);

    logic [15:0] pre;
    logic [7:0]  cnt;
    logic        tick;
    logic        pwm_bit;

    assign tick    = (pre == 16'(DIV - 1));
    assign wrap    = tick && (cnt == 8'hFF);
    // duty 0xFF means fully on, which plain cnt < duty cannot express
    assign pwm_bit = (duty == 8'hFF) || (cnt < duty);

    // Prescaler and counter: cnt steps once every DIV clocks, wrapping naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
            cnt <= '0;
        end else if (tick) begin
            pre <= '0;
            cnt <= cnt + 8'd1;
        end else begin
            pre <= pre + 16'd1;
        end
    end

    // Registered output: disabled -> 0, static -> 1, otherwise the PWM compare
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out <= '0;
        end else begin
            pwm_out <= en_out & (~en_pwm | {16{pwm_bit}});
        end
    end

endmodule

// File: rtl/pwm_reg_scheduler.sv
// Two-requester register write port (SPI / host) with round-robin arbitration,
// shadow registers and period-aligned commit into the active PWM registers.
module pwm_reg_scheduler #(
    parameter int MAX_ADDR = pwm_pkg::MAX_ADDR,
    parameter int DIV      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_req,
    input  logic [6:0]  spi_addr,
    input  logic [7:0]  spi_data,
    input  logic        host_req,
    input  logic [6:0]  host_addr,
    input  logic [7:0]  host_data,
    output logic        spi_ack,
    output logic        host_ack,
    output logic        wr_err,
    output logic [15:0] pwm_out,
    output logic        commit
);

    import pwm_pkg::arb_state_e;
    import pwm_pkg::IDLE;
    import pwm_pkg::ACK;
    import pwm_pkg::wr_req_t;
    import pwm_pkg::NUM_REGS;
    import pwm_pkg::ADDR_EN_OUT_LO;
    import pwm_pkg::ADDR_EN_OUT_HI;
    import pwm_pkg::ADDR_EN_PWM_LO;
    import pwm_pkg::ADDR_EN_PWM_HI;
    import pwm_pkg::ADDR_DUTY;

    arb_state_e               state;
    logic                     rr_host;    // 1: host wins the next contended grant
    logic                     sel_host;
    logic                     grant_host;
    wr_req_t                  req_in;
    wr_req_t                  req_q;
    logic                     wr_bad;
    logic                     wr_en;
    logic                     wrap;
    logic                     dirty;
    logic [NUM_REGS-1:0][7:0] shadow;
    logic [NUM_REGS-1:0][7:0] active;

    // A lone requester always wins; on contention rr_host decides
    assign grant_host = host_req && (!spi_req || rr_host);
    assign req_in     = grant_host ? {host_addr, host_data} : {spi_addr, spi_data};
    assign wr_bad     = int'(req_q.addr) > MAX_ADDR;
    assign wr_en      = (state == ACK) && !wr_bad && (int'(req_q.addr) < NUM_REGS);

    // Arbiter: grant and latch in IDLE, ack (and flag bad address) leaving ACK
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_host  <= 1'b0;
            sel_host <= 1'b0;
            req_q    <= '0;
            spi_ack  <= 1'b0;
            host_ack <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            spi_ack  <= 1'b0;
            host_ack <= 1'b0;
            wr_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (spi_req || host_req) begin
                        sel_host <= grant_host;
                        req_q    <= req_in;
                        rr_host  <= !rr_host;
                        state    <= ACK;
                    end
                end
                ACK: begin
                    spi_ack  <= !sel_host;
                    host_ack <= sel_host;
                    wr_err   <= wr_bad;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Shadow/active registers: commit copies pre-write shadow; a same-cycle write keeps dirty set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            active <= '0;
            dirty  <= 1'b0;
            commit <= 1'b0;
        end else begin
            commit <= 1'b0;
            if (wrap && dirty) begin
                active <= shadow;
                dirty  <= 1'b0;
                commit <= 1'b1;
            end
            if (wr_en) begin
                shadow[req_q.addr[2:0]] <= req_q.data;
                dirty                   <= 1'b1;
            end
        end
    end

    pwm_gen #(
        .DIV(DIV)
    ) u_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_out  ({active[ADDR_EN_OUT_HI], active[ADDR_EN_OUT_LO]}),
        .en_pwm  ({active[ADDR_EN_PWM_HI], active[ADDR_EN_PWM_LO]}),
        .duty    (active[ADDR_DUTY]),
        .pwm_out (pwm_out),
        .wrap    (wrap)
    );

endmodule

// File: tb/tb_pwm_reg_scheduler.sv
// Bench for pwm_reg_scheduler: directed scenarios plus random writes, checked
// every cycle against a transaction-level model (period arithmetic, register arrays).
module tb_pwm_reg_scheduler;

    localparam int DIV      = 2;
    localparam int PERIOD   = 256 * DIV;
    localparam int MAX_ADDR = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        spi_req = 1'b0;
    logic [6:0]  spi_addr = '0;
    logic [7:0]  spi_data = '0;
    logic        host_req = 1'b0;
    logic [6:0]  host_addr = '0;
    logic [7:0]  host_data = '0;
    logic        spi_ack;
    logic        host_ack;
    logic        wr_err;
    logic [15:0] pwm_out;
    logic        commit;

    always #5 clk = ~clk;

    pwm_reg_scheduler #(
        .MAX_ADDR(MAX_ADDR),
        .DIV(DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_req   (spi_req),
        .spi_addr  (spi_addr),
        .spi_data  (spi_data),
        .host_req  (host_req),
        .host_addr (host_addr),
        .host_data (host_data),
        .spi_ack   (spi_ack),
        .host_ack  (host_ack),
        .wr_err    (wr_err),
        .pwm_out   (pwm_out),
        .commit    (commit)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    endtask

    // reference model state
    logic [7:0] m_shadow [5];
    logic [7:0] m_active [5];
    bit         m_dirty;
    bit         m_rr_host;
    int         e;                      // rising edges since reset release
    int         spi_land, host_land;    // edge on which each pending write lands
    logic [6:0] spi_la, host_la;
    logic [7:0] spi_ld, host_ld;
    int         hi0, nz, ff, ncommit;   // observation counters over a window

    function automatic logic [15:0] ref_pwm(input int c);
        logic [15:0] eo, ep, r;
        int d;
        eo = {m_active[1], m_active[0]};
        ep = {m_active[3], m_active[2]};
        d  = m_active[4];
        for (int i = 0; i < 16; i++)
            r[i] = !eo[i] ? 1'b0 : (!ep[i] ? 1'b1 : (d == 255 || c < d));
        return r;
    endfunction

    function automatic bit model_wr(input logic [6:0] a, input logic [7:0] d);
        if (int'(a) > MAX_ADDR) return 1'b1;
        m_shadow[a] = d;
        m_dirty = 1'b1;
        return 1'b0;
    endfunction

    // one clock: advance the model for this edge, then compare at the falling edge
    task automatic step();
        logic [15:0] exp_pwm;
        bit ec, es, eh, ee;
        ec = 0; es = 0; eh = 0; ee = 0;
        @(posedge clk);
        e++;
        exp_pwm = ref_pwm(((e - 1) / DIV) % 256);
        if (e % PERIOD == 0 && m_dirty) begin
            for (int i = 0; i < 5; i++) m_active[i] = m_shadow[i];
            m_dirty = 1'b0;
            ec = 1;
        end
        if (e == spi_land) begin es = 1; ee = model_wr(spi_la, spi_ld); end
        if (e == host_land) begin eh = 1; ee = model_wr(host_la, host_ld); end
        @(negedge clk);
        chk("pwm_out", pwm_out, exp_pwm);
        chk("commit", commit, ec);
        chk("spi_ack", spi_ack, es);
        chk("host_ack", host_ack, eh);
        chk("wr_err", wr_err, ee);
        hi0 += int'(pwm_out[0]);
        if (pwm_out == 16'h0000) nz++;
        if (pwm_out == 16'hFFFF) ff++;
        if (commit) ncommit++;
        if (e == spi_land) spi_req = 1'b0;
        if (e == host_land) host_req = 1'b0;
    endtask

    task automatic run_to(input int ph);
        do step(); while (e % PERIOD != ph);
    endtask

    // raise one or both requests from idle; grant on the next edge, land one edge later
    task automatic issue(input bit us, input bit uh, input logic [6:0] sa, input logic [7:0] sd,
                         input logic [6:0] ha, input logic [7:0] hd);
        int first;
        first = e + 2;
        spi_addr = sa; spi_data = sd; host_addr = ha; host_data = hd;
        spi_la = sa; spi_ld = sd; host_la = ha; host_ld = hd;
        spi_req = us; host_req = uh;
        if (us && uh) begin
            if (m_rr_host) begin host_land = first; spi_land = first + 2; end
            else begin spi_land = first; host_land = first + 2; end
        end else if (us) begin
            spi_land = first; m_rr_host = !m_rr_host;
        end else if (uh) begin
            host_land = first; m_rr_host = !m_rr_host;
        end
        repeat ((us && uh) ? 4 : 2) step();
    endtask

    task automatic spi_wr(input logic [6:0] a, input logic [7:0] d);
        issue(1'b1, 1'b0, a, d, 7'd0, 8'd0);
    endtask

    task automatic assert_rst();
        rst_n = 1'b0;
        spi_req = 1'b0;
        host_req = 1'b0;
        #1;
        chk("rst_pwm_out", pwm_out, 16'h0000);
        chk("rst_spi_ack", spi_ack, 1'b0);
        chk("rst_host_ack", host_ack, 1'b0);
        chk("rst_wr_err", wr_err, 1'b0);
        chk("rst_commit", commit, 1'b0);
        for (int i = 0; i < 5; i++) begin m_shadow[i] = '0; m_active[i] = '0; end
        m_dirty = 0; m_rr_host = 0; e = 0; spi_land = -1; host_land = -1;
    endtask

    task automatic release_rst();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        assert_rst();
        release_rst();

        // basic writes: duty 50%, bits 7:0 enabled, only bit 0 modulated
        spi_wr(7'd4, 8'h80);
        spi_wr(7'd0, 8'hFF);
        spi_wr(7'd2, 8'h01);
        run_to(0);
        hi0 = 0;
        repeat (PERIOD) step();
        chk("duty50_hi_cycles", hi0, 128 * DIV);
        chk("static_bits_7_1", pwm_out[7:1], 7'h7F);

        // duty 0 then 0xFF with everything enabled
        spi_wr(7'd0, 8'hFF); spi_wr(7'd1, 8'hFF);
        spi_wr(7'd2, 8'hFF); spi_wr(7'd3, 8'hFF);
        spi_wr(7'd4, 8'h00);
        run_to(0);
        nz = 0;
        repeat (PERIOD) step();
        chk("duty00_all_zero", nz, PERIOD);
        spi_wr(7'd4, 8'hFF);
        run_to(0);
        ff = 0;
        repeat (PERIOD) step();
        chk("dutyFF_all_one", ff, PERIOD);

        // write landing on the wrap edge: old value commits now, new one next period
        spi_wr(7'd4, 8'h40);
        run_to(PERIOD - 2);
        spi_wr(7'd4, 8'hC0);
        ncommit = 0;
        run_to(0);
        step();
        chk("late_write_recommit", ncommit, 1);

        // reset in the middle of ACK: write lost, no ack, outputs cleared
        spi_addr = 7'd4; spi_data = 8'h11; spi_req = 1'b1;
        @(posedge clk);
        #2;
        assert_rst();
        release_rst();
        ncommit = 0;
        repeat (PERIOD + 4) step();
        chk("lost_write_no_commit", ncommit, 0);

        // simultaneous requests twice: rr starts at SPI after reset
        issue(1'b1, 1'b1, 7'd0, 8'hA5, 7'd1, 8'h5A);
        issue(1'b1, 1'b1, 7'd2, 8'hF0, 7'd3, 8'h0F);
        run_to(0);

        // out-of-range host write: acked with error, no register change, no commit
        issue(1'b0, 1'b1, 7'd0, 8'd0, 7'd5, 8'hEE);
        ncommit = 0;
        run_to(0);
        step();
        chk("bad_addr_no_commit", ncommit, 0);

        // random traffic, sometimes aimed at the wrap edge
        for (int n = 0; n < 40; n++) begin
            bit us, uh;
            us = 1'($urandom_range(0, 1));
            uh = 1'($urandom_range(0, 1));
            if (!us && !uh) us = 1'b1;
            if ($urandom_range(0, 4) == 0) run_to(PERIOD - 2);
            issue(us, uh, 7'($urandom_range(0, 6)), 8'($urandom),
                  7'($urandom_range(0, 6)), 8'($urandom));
            repeat ($urandom_range(0, 40)) step();
        end
        run_to(0);
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
